// File: rtl/packet_arbiter_pkg.sv
// Shared types and helpers for the packet arbiter: FSM state encoding,
// drop counter width and the saturating orphan-count arithmetic.
package pkt_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int DROP_CNT_WIDTH = 16;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + 4'(v[i]);
    end
    return cnt;
  endfunction

  // Counter sticks at all-ones instead of wrapping back to a small value.
  function automatic logic [DROP_CNT_WIDTH-1:0] sat_add(
    input logic [DROP_CNT_WIDTH-1:0] a,
    input logic [3:0]                b
  );
    logic [DROP_CNT_WIDTH:0] sum;
    sum = {1'b0, a} + {{(DROP_CNT_WIDTH-3){1'b0}}, b};
    return sum[DROP_CNT_WIDTH] ? '1 : sum[DROP_CNT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/packet_arbiter_if.sv
// Avalon-ST stream bundle; the sink modport is the receiving side of a stream,
// the src modport the driving side.
interface avalon_st_if #(
  parameter int DWIDTH = 64,
  parameter int CWIDTH = 1
);
  localparam int EWIDTH = $clog2(DWIDTH/8);

  logic [DWIDTH-1:0] data;
  logic              valid;
  logic              ready;
  logic              startofpacket;
  logic              endofpacket;
  logic [EWIDTH-1:0] empty;
  logic [CWIDTH-1:0] channel;

  modport sink (
    input  data, valid, startofpacket, endofpacket, empty, channel,
    output ready
  );

  modport src (
    output data, valid, startofpacket, endofpacket, empty, channel,
    input  ready
  );
endinterface

// File: rtl/packet_arbiter_rr.sv
// Combinational round-robin pick: first requester strictly after last_grant,
// wrapping modulo NUM_SRC.
module rr_arbiter #(
  parameter  int NUM_SRC     = 2,
  localparam int GRANT_WIDTH = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]     req_i,
  input  logic [GRANT_WIDTH-1:0] last_grant_i,
  output logic [GRANT_WIDTH-1:0] next_grant_o,
  output logic                   any_req_o
);

  assign any_req_o = |req_i;

  always_comb begin
    int   idx;
    logic found;
    next_grant_o = last_grant_i;
    found        = 1'b0;
    idx          = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(last_grant_i) + k) % NUM_SRC;
      if (!found && req_i[idx]) begin
        next_grant_o = GRANT_WIDTH'(idx);
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/packet_arbiter.sv
// Merges NUM_SRC Avalon-ST sources into one stream, one whole packet at a time,
// with round-robin arbitration and discard/count of orphan (sop-less) words.
//
// state | meaning
// IDLE  | no packet owned; arbitrate sop requesters, accept and drop orphan words
// BUSY  | granted source passed straight through to src until its eop transfer
module packet_arbiter
  import pkt_arb_pkg::*;
#(
  parameter  int AST_DWIDTH    = 64,
  parameter  int CHANNEL_WIDTH = 1,
  parameter  int NUM_SRC       = 2,
  localparam int GRANT_WIDTH   = $clog2(NUM_SRC),
  localparam int EMPTY_WIDTH   = $clog2(AST_DWIDTH/8)
) (
  input  logic                      clk_i,
  input  logic                      arst_n_i,
  avalon_st_if.sink                 ast_sink_if [NUM_SRC],
  avalon_st_if.src                  ast_src_if,
  output logic [GRANT_WIDTH-1:0]    grant_o,
  output logic                      busy_o,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);

  logic [1:0]                rst_sync_q;
  logic                      rst_n;
  arb_state_e                state_q;
  logic [GRANT_WIDTH-1:0]    grant_q;
  logic [GRANT_WIDTH-1:0]    last_grant_q;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_d;

  logic [AST_DWIDTH-1:0]  snk_data  [NUM_SRC];
  logic [EMPTY_WIDTH-1:0] snk_empty [NUM_SRC];
  logic [NUM_SRC-1:0]     snk_valid;
  logic [NUM_SRC-1:0]     snk_sop;
  logic [NUM_SRC-1:0]     snk_eop;
  logic [NUM_SRC-1:0]     snk_ready;
  logic [NUM_SRC-1:0]     req;
  logic [NUM_SRC-1:0]     orphan_idle;
  logic [GRANT_WIDTH-1:0] next_grant;
  logic                   any_req;
  logic                   xfer_eop;

  // Assert immediately, release two edges after arst_n_i rises.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) rst_sync_q <= 2'b00;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_snk
    assign snk_data[g]         = ast_sink_if[g].data;
    assign snk_empty[g]        = ast_sink_if[g].empty;
    assign snk_valid[g]        = ast_sink_if[g].valid;
    assign snk_sop[g]          = ast_sink_if[g].startofpacket;
    assign snk_eop[g]          = ast_sink_if[g].endofpacket;
    assign ast_sink_if[g].ready = snk_ready[g];
  end

  assign req         = snk_valid & snk_sop;
  assign orphan_idle = (state_q == IDLE && rst_n) ? (snk_valid & ~snk_sop) : '0;
  assign drop_cnt_d  = sat_add(drop_cnt_q, popcount8(8'(orphan_idle)));

  rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .next_grant_o (next_grant),
    .any_req_o    (any_req)
  );

  always_comb begin
    ast_src_if.data          = '0;
    ast_src_if.valid         = 1'b0;
    ast_src_if.startofpacket = 1'b0;
    ast_src_if.endofpacket   = 1'b0;
    ast_src_if.empty         = '0;
    ast_src_if.channel       = '0;
    snk_ready                = orphan_idle;
    if (state_q == BUSY) begin
      ast_src_if.data          = snk_data[grant_q];
      ast_src_if.valid         = snk_valid[grant_q];
      ast_src_if.startofpacket = snk_sop[grant_q];
      ast_src_if.endofpacket   = snk_eop[grant_q];
      ast_src_if.empty         = snk_empty[grant_q];
      ast_src_if.channel       = CHANNEL_WIDTH'(grant_q);
      snk_ready                = '0;
      snk_ready[grant_q]       = ast_src_if.ready;
    end
  end

  assign xfer_eop = (state_q == BUSY) && ast_src_if.valid && ast_src_if.ready
                    && ast_src_if.endofpacket;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GRANT_WIDTH'(NUM_SRC-1);
      drop_cnt_q   <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q      <= next_grant;
            last_grant_q <= next_grant;
            state_q      <= BUSY;
          end
        end
        BUSY: begin
          if (xfer_eop) state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant_o    = grant_q;
  assign busy_o     = (state_q == BUSY);
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_packet_arbiter.sv
// Bench for packet_arbiter: reset/IDLE vector table, directed packet sequences
// and randomized traffic checked by a packet-level scoreboard.
module tb_packet_arbiter;
  localparam int NUM_SRC = 2;
  localparam int DW      = 64;
  localparam int CW      = 1;
  localparam int EW      = 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } word_t;

  typedef struct {
    int    cyc;
    int    chan;
    word_t w;
  } out_t;

  typedef struct {
    logic [1:0] v;
    logic [1:0] s;
    logic [1:0] rdy;
    int         drop_d;
    bit         busy_n;
    logic       g_n;
  } vec_t;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  avalon_st_if #(.DWIDTH(DW), .CWIDTH(CW)) snk_if [NUM_SRC] ();
  avalon_st_if #(.DWIDTH(DW), .CWIDTH(CW)) src_if ();

  logic        grant;
  logic        busy;
  logic [15:0] drop_cnt;

  word_t              cur_w [NUM_SRC];
  logic [NUM_SRC-1:0] s_valid = '0;
  logic [NUM_SRC-1:0] s_ready;
  logic               src_rdy = 1'b1;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_drv
    assign snk_if[g].data          = cur_w[g].data;
    assign snk_if[g].startofpacket = cur_w[g].sop;
    assign snk_if[g].endofpacket   = cur_w[g].eop;
    assign snk_if[g].empty         = cur_w[g].empty;
    assign snk_if[g].channel       = '0;
    assign snk_if[g].valid         = s_valid[g];
    assign s_ready[g]              = snk_if[g].ready;
  end
  assign src_if.ready = src_rdy;

  packet_arbiter #(.AST_DWIDTH(DW), .CHANNEL_WIDTH(CW), .NUM_SRC(NUM_SRC)) dut (
    .clk_i       (clk),
    .arst_n_i    (arst_n),
    .ast_sink_if (snk_if),
    .ast_src_if  (src_if),
    .grant_o     (grant),
    .busy_o      (busy),
    .drop_cnt_o  (drop_cnt)
  );

  int total = 0;
  int bad   = 0;

  word_t drv_q [NUM_SRC][$];
  word_t exp_q [NUM_SRC][$];
  out_t  log_q [$];

  int                 last_w;
  bit                 in_pkt;
  int                 cur_c;
  logic [NUM_SRC-1:0] idle_req;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Arbitration rule: first requester after the previous winner, wrapping.
  function automatic int rr_pick(input int last, input logic [NUM_SRC-1:0] r);
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (r[(last + k) % NUM_SRC]) return (last + k) % NUM_SRC;
    end
    return -1;
  endfunction

  task automatic model_reset();
    last_w   = NUM_SRC - 1;
    in_pkt   = 1'b0;
    cur_c    = 0;
    idle_req = '0;
  endtask

  task automatic do_reset();
    arst_n  = 1'b0;
    s_valid = '0;
    src_rdy = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin
      drv_q[i].delete();
      exp_q[i].delete();
    end
    repeat (3) @(posedge clk);
    @(negedge clk) arst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic new_pkt(input int src, input int len, input int emp, input int base, input bit mid_sop);
    word_t w;
    for (int j = 0; j < len; j++) begin
      w.data  = (64'(src) << 48) | (64'(base) << 16) | 64'(j);
      w.sop   = (j == 0) || (mid_sop && j == len / 2);
      w.eop   = (j == len - 1);
      w.empty = w.eop ? EW'(emp) : '0;
      drv_q[src].push_back(w);
      exp_q[src].push_back(w);
    end
  endtask

  task automatic score();
    int    c;
    word_t got;
    word_t e;
    c   = int'(src_if.channel);
    got = {src_if.data, src_if.startofpacket, src_if.endofpacket, src_if.empty};
    check("grant_vs_channel", 128'(grant), 128'(c));
    check("word_expected_on_ch", 128'(exp_q[c].size() > 0), 128'(1));
    if (exp_q[c].size() > 0) begin
      e = exp_q[c].pop_front();
      check("word_content", 128'(got), 128'(e));
    end
    if (!in_pkt) begin
      check("pkt_start_sop", 128'(got.sop), 128'(1));
      check("rr_winner", 128'(c), 128'(rr_pick(last_w, idle_req)));
      last_w = c;
      cur_c  = c;
      in_pkt = 1'b1;
    end else begin
      check("no_interleave", 128'(c), 128'(cur_c));
    end
    if (got.eop) in_pkt = 1'b0;
    log_q.push_back('{cyc, c, got});
  endtask

  // Drives queued words with valid held until accepted; rmode 0=ready high,
  // 1=ready toggling, 2=ready random.
  task automatic run_traffic(input int vprob, input int rmode, input int stop_words, input int budget);
    int                 n;
    int                 remaining;
    logic [NUM_SRC-1:0] acc;
    logic [NUM_SRC-1:0] sopv;
    log_q.delete();
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      acc = s_valid & s_ready;
      for (int i = 0; i < NUM_SRC; i++) sopv[i] = cur_w[i].sop;
      if (!busy) idle_req = s_valid & sopv;
      if (src_if.valid && src_if.ready) score();
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (acc[i]) begin
          void'(drv_q[i].pop_front());
          s_valid[i] = 1'b0;
        end
        if (!s_valid[i] && drv_q[i].size() > 0 && $urandom_range(0, 99) < vprob) begin
          cur_w[i]   = drv_q[i][0];
          s_valid[i] = 1'b1;
        end
      end
      case (rmode)
        0:       src_rdy = 1'b1;
        1:       src_rdy = ~src_rdy;
        default: src_rdy = ($urandom_range(0, 99) < 70);
      endcase
      n++;
      if (stop_words > 0 && log_q.size() >= stop_words) break;
      remaining = 0;
      for (int i = 0; i < NUM_SRC; i++) remaining += exp_q[i].size();
      if (stop_words == 0 && remaining == 0) break;
    end
    if (stop_words > 0) begin
      check("stop_words_reached", 128'(log_q.size() >= stop_words), 128'(1));
    end else begin
      remaining = 0;
      for (int i = 0; i < NUM_SRC; i++) remaining += exp_q[i].size();
      check("all_words_delivered", 128'(remaining), 128'(0));
    end
    src_rdy = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [$];
    logic [15:0] d0;
    logic [15:0] dsave;
    int          nlen;

    for (int i = 0; i < NUM_SRC; i++) cur_w[i] = '0;
    model_reset();

    // ---- reset values, orphan held through reset and synchroniser release
    arst_n      = 1'b0;
    cur_w[1]    = '{data: 64'hDEAD, sop: 1'b0, eop: 1'b0, empty: '0};
    s_valid     = 2'b10;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_grant", 128'(grant), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_drop", 128'(drop_cnt), 128'(0));
    check("rst_src_valid", 128'(src_if.valid), 128'(0));
    check("rst_sink_ready", 128'(s_ready), 128'(0));
    arst_n = 1'b1;
    @(negedge clk);
    check("sync_stage1_ready", 128'(s_ready), 128'(0));
    @(negedge clk);
    check("sync_done_ready", 128'(s_ready), 128'(2'b10));
    check("sync_done_drop", 128'(drop_cnt), 128'(0));
    @(negedge clk);
    check("first_orphan_drop", 128'(drop_cnt), 128'(1));
    s_valid = '0;

    do_reset();
    cur_w[0] = '{data: 64'hA0, sop: 1'b1, eop: 1'b1, empty: '0};
    cur_w[1] = '{data: 64'hA1, sop: 1'b1, eop: 1'b1, empty: '0};
    s_valid  = 2'b11;
    @(posedge clk);
    #1;
    check("first_winner_src0", 128'(grant), 128'(0));
    @(negedge clk);
    check("first_word_ch0", 128'(src_if.channel), 128'(0));
    s_valid = '0;

    // ---- IDLE vector table: {valid, sop} -> ready, drop delta, next busy/grant
    tbl.push_back('{2'b00, 2'b00, 2'b00, 0, 1'b0, 1'b0});
    tbl.push_back('{2'b10, 2'b00, 2'b10, 1, 1'b0, 1'b0});
    tbl.push_back('{2'b11, 2'b00, 2'b11, 2, 1'b0, 1'b0});
    tbl.push_back('{2'b01, 2'b01, 2'b00, 0, 1'b1, 1'b0});
    tbl.push_back('{2'b11, 2'b11, 2'b00, 0, 1'b1, 1'b1});
    tbl.push_back('{2'b11, 2'b11, 2'b00, 0, 1'b1, 1'b0});
    tbl.push_back('{2'b11, 2'b01, 2'b10, 1, 1'b1, 1'b0});
    tbl.push_back('{2'b10, 2'b10, 2'b00, 0, 1'b1, 1'b1});
    tbl.push_back('{2'b11, 2'b10, 2'b01, 1, 1'b1, 1'b1});
    tbl.push_back('{2'b01, 2'b00, 2'b01, 1, 1'b0, 1'b1});
    tbl.push_back('{2'b00, 2'b11, 2'b00, 0, 1'b0, 1'b1});
    tbl.push_back('{2'b11, 2'b11, 2'b00, 0, 1'b1, 1'b0});
    do_reset();
    foreach (tbl[r]) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        cur_w[i] = '{data: 64'(100 + i), sop: tbl[r].s[i], eop: 1'b1, empty: '0};
      end
      s_valid = tbl[r].v;
      @(negedge clk);
      d0 = drop_cnt;
      check($sformatf("tbl%0d_ready", r), 128'(s_ready), 128'(tbl[r].rdy));
      check($sformatf("tbl%0d_src_valid", r), 128'(src_if.valid), 128'(0));
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_busy", r), 128'(busy), 128'(tbl[r].busy_n));
      check($sformatf("tbl%0d_grant", r), 128'(grant), 128'(tbl[r].g_n));
      check($sformatf("tbl%0d_drop", r), 128'(drop_cnt - d0), 128'(tbl[r].drop_d));
      s_valid = '0;
      if (tbl[r].busy_n) begin
        s_valid[tbl[r].g_n] = 1'b1;
        @(negedge clk);
        check($sformatf("tbl%0d_pass_valid", r), 128'(src_if.valid), 128'(1));
        check($sformatf("tbl%0d_pass_ch", r), 128'(src_if.channel), 128'(tbl[r].g_n));
        @(posedge clk);
        #1;
        s_valid = '0;
        check($sformatf("tbl%0d_back_idle", r), 128'(busy), 128'(0));
      end
    end

    // ---- round robin, 4-word packets back to back
    do_reset();
    for (int p = 0; p < 2; p++) begin
      new_pkt(0, 4, 0, p, 1'b0);
      new_pkt(1, 4, 0, p, 1'b0);
    end
    run_traffic(100, 0, 0, 200);
    check("rr_words", 128'(log_q.size()), 128'(16));
    if (log_q.size() == 16) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("rr_order%0d", k), 128'(log_q[4*k].chan), 128'(k % 2));
        if (k > 0) check($sformatf("rr_gap%0d", k), 128'(log_q[4*k].cyc - log_q[4*k-1].cyc), 128'(2));
      end
    end

    // ---- backpressure on a 5-word packet
    do_reset();
    new_pkt(0, 5, 5, 7, 1'b0);
    run_traffic(100, 1, 0, 200);
    check("bp_words", 128'(log_q.size()), 128'(5));
    if (log_q.size() == 5) begin
      for (int k = 0; k < 5; k++) check($sformatf("bp_order%0d", k), 128'(log_q[k].w.data[15:0]), 128'(k));
      check("bp_sop_first", 128'(log_q[0].w.sop), 128'(1));
      check("bp_eop_last", 128'(log_q[4].w.eop), 128'(1));
      check("bp_empty_last", 128'(log_q[4].w.empty), 128'(5));
    end

    // ---- orphan words on source 1, then a proper packet
    do_reset();
    cur_w[1] = '{data: 64'hBEEF, sop: 1'b0, eop: 1'b0, empty: '0};
    s_valid  = 2'b10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("orph%0d_src_valid", k), 128'(src_if.valid), 128'(0));
      check($sformatf("orph%0d_ready", k), 128'(s_ready[1]), 128'(1));
      @(posedge clk);
      #1;
    end
    s_valid = '0;
    check("orph_drop3", 128'(drop_cnt), 128'(3));
    new_pkt(1, 3, 2, 9, 1'b0);
    run_traffic(100, 0, 0, 100);
    check("orph_follow_words", 128'(log_q.size()), 128'(3));
    check("orph_drop_after", 128'(drop_cnt), 128'(3));

    // ---- sop inside a packet is forwarded, packet ends only on eop
    do_reset();
    new_pkt(0, 4, 1, 3, 1'b1);
    new_pkt(1, 2, 0, 4, 1'b0);
    run_traffic(100, 0, 0, 100);
    check("midsop_words", 128'(log_q.size()), 128'(6));
    if (log_q.size() == 6) begin
      check("midsop_flag", 128'(log_q[2].w.sop), 128'(1));
      check("midsop_same_ch", 128'(log_q[3].chan), 128'(0));
    end

    // ---- reset in the middle of a 6-word packet
    do_reset();
    new_pkt(0, 6, 0, 5, 1'b0);
    run_traffic(100, 0, 2, 50);
    arst_n = 1'b0;
    #1;
    check("midrst_src_valid", 128'(src_if.valid), 128'(0));
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_ready", 128'(s_ready), 128'(0));
    for (int i = 0; i < NUM_SRC; i++) begin
      drv_q[i].delete();
      exp_q[i].delete();
    end
    s_valid = '0;
    @(negedge clk) arst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    new_pkt(1, 3, 0, 6, 1'b0);
    run_traffic(100, 0, 0, 100);
    check("midrst_new_words", 128'(log_q.size()), 128'(3));
    if (log_q.size() > 0) check("midrst_new_ch", 128'(log_q[0].chan), 128'(1));
    check("midrst_grant", 128'(grant), 128'(1));

    // ---- single-word packets from both sources
    do_reset();
    for (int p = 0; p < 4; p++) begin
      new_pkt(0, 1, 0, 20 + p, 1'b0);
      new_pkt(1, 1, 0, 30 + p, 1'b0);
    end
    run_traffic(100, 0, 0, 100);
    check("single_words", 128'(log_q.size()), 128'(8));
    if (log_q.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        check($sformatf("single_ch%0d", k), 128'(log_q[k].chan), 128'(k % 2));
        if (k > 0) check($sformatf("single_gap%0d", k), 128'(log_q[k].cyc - log_q[k-1].cyc), 128'(2));
      end
    end

    // ---- randomized traffic
    do_reset();
    dsave = drop_cnt;
    for (int p = 0; p < 10; p++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        nlen = $urandom_range(1, 6);
        new_pkt(i, nlen, $urandom_range(0, 7), 100 + p, 1'b0);
      end
    end
    run_traffic(60, 2, 0, 4000);
    check("rand_drop_unchanged", 128'(drop_cnt), 128'(dsave));

    // ---- drop counter saturation with two orphans per cycle
    do_reset();
    cur_w[0] = '{data: 64'h1, sop: 1'b0, eop: 1'b0, empty: '0};
    cur_w[1] = '{data: 64'h2, sop: 1'b0, eop: 1'b0, empty: '0};
    s_valid  = 2'b11;
    repeat (32767) @(posedge clk);
    #1;
    check("sat_before", 128'(drop_cnt), 128'(16'hFFFE));
    @(posedge clk);
    #1;
    check("sat_reach", 128'(drop_cnt), 128'(16'hFFFF));
    @(posedge clk);
    #1;
    check("sat_hold", 128'(drop_cnt), 128'(16'hFFFF));
    s_valid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/packet_arbiter.md
PACKET_ARBITER -- requirements
Module: packet_arbiter

Interface
REQ-001 Parameter AST_DWIDTH, default 64: Avalon-ST data width, in bits.
REQ-002 Parameter CHANNEL_WIDTH, default 1: channel width; SHALL be >= $clog2(NUM_SRC).
REQ-003 Parameter NUM_SRC, default 2: number of competing Avalon-ST sources; legal range 2..8.
REQ-004 Derived constant EMPTY_WIDTH = $clog2(AST_DWIDTH/8).
REQ-005 clk_i  input  1  single clock; all logic is on the rising edge.
REQ-006 arst_n_i  input  1  reset, asynchronous and active-low.
REQ-007 ast_sink_if[NUM_SRC]  avalon_st_if.sink  data/valid/ready/sop/eop/empty/channel  the requesting sources.
REQ-008 ast_src_if  avalon_st_if.src  same fields  merged stream, feeds the packet classer sink.
REQ-009 grant_o  output  $clog2(NUM_SRC)  index of the current or last granted source.
REQ-010 busy_o  output  1  high while a packet is being forwarded.
REQ-011 drop_cnt_o  output  16  count of orphan words discarded; saturates at 16'hFFFF.

Function
REQ-012 FSM states: IDLE and BUSY.
REQ-013 IDLE: all sink ready=0, except as REQ-018 requires; src valid=0.
REQ-014 Request of source i = sink[i].valid & sink[i].startofpacket.
REQ-015 IDLE with at least one request: grant goes to the first requester after last_grant, searching round-robin modulo NUM_SRC.
- grant_o and last_grant are registered.
- The FSM goes to BUSY on the next edge.
- Arbitration costs exactly 1 bubble cycle per packet.
REQ-016 BUSY, combinational pass-through with zero latency:
- src.data/valid/sop/eop/empty = sink[grant] fields.
- src.channel = grant index, zero-extended to CHANNEL_WIDTH.
- sink[grant].ready = src.ready.
- Every other sink has ready=0.
REQ-017 Transfer = src.valid & src.ready. A transfer with eop in BUSY returns the FSM to IDLE on the next edge.
REQ-018 Orphan words:
- Condition: in IDLE, a sink with valid=1 and sop=0.
- That sink is given ready=1 and the word is discarded.
- drop_cnt_o increments by 1 per discarded word.
- Multiple orphans in one cycle: increment by the popcount of orphan sinks.
REQ-019 Packets are never interleaved: no grant change while in BUSY, whatever the other requests are.
REQ-020 A sop arriving mid-packet on the granted source is forwarded unchanged; the packet still ends only on eop.
REQ-021 Single-word packet (sop & eop in one transfer): BUSY lasts 1 cycle, then IDLE.
REQ-022 src.ready low in BUSY: the FSM holds its state and sink[grant].ready=0; no data is lost or duplicated.
REQ-023 Fairness: with all NUM_SRC sources requesting continuously, each source is granted exactly once per NUM_SRC packets.
REQ-024 busy_o = (state == BUSY).

Reset
REQ-025 arst_n_i low, whatever the clock is doing:
- state=IDLE
- last_grant=NUM_SRC-1, so source 0 wins first
- grant_o=0
- drop_cnt_o=0
- busy_o=0
- src valid=0
- all sink ready=0
REQ-026 Reset mid-packet: the packet is abandoned and no eop is generated. After release the block re-arbitrates from REQ-025 values; sources must resend from sop.
REQ-027 Reset release is synchronised internally: 2-flop deassertion synchroniser, assertion stays asynchronous.

Structure
REQ-028 Package pkt_arb_pkg SHALL hold the FSM state enum (IDLE, BUSY) and the DROP_CNT_WIDTH=16 constant.
REQ-029 The round-robin pick SHALL be a combinational sub-module rr_arbiter.
- Inputs: request vector, last_grant.
- Outputs: next_grant, any_req.
REQ-030 All state-holding logic SHALL reside in packet_arbiter; the datapath mux is combinational.

Verification
REQ-031 Reset value: hold arst_n_i low for 3 cycles -> grant_o=0, busy_o=0, drop_cnt_o=0, src valid=0; src0 request then wins first.
REQ-032 Round-robin: NUM_SRC=2, both sources send back-to-back 4-word packets, src.ready=1 -> output order src0,src1,src0,src1.
- channel toggles 0,1,0,1.
- 1 idle cycle between packets.
REQ-033 Backpressure: src.ready toggled 1/0 every cycle during a 5-word packet -> all 5 words appear once, in order; sop on word 1, eop and empty on word 5.
REQ-034 Orphan drop: in IDLE, source 1 drives 3 valid words without sop -> drop_cnt_o=3; none reach src; a following source 1 sop packet is forwarded intact.
REQ-035 Reset mid-packet: assert arst_n_i after word 2 of 6 -> src valid=0 immediately; after release a new packet from source 1 is granted, with grant_o=1 and channel=1.
REQ-036 Single-word packets: both sources send sop&eop words continuously -> alternate grants; one word is forwarded every 2 cycles.
